// File: rtl/test_pkg.sv
// Shared types for the RISC-MGMT test extension: funct codes, the 32-bit
// instruction word layout and the command record consumed by the encoder.
package test_pkg;

    typedef enum logic [3:0] {
        TEST_RTYPE     = 4'd0,
        TEST_ITYPE     = 4'd1,
        TEST_BRANCH    = 4'd2,
        TEST_MEM_LOAD  = 4'd3,
        TEST_MEM_STORE = 4'd4,
        TEST_CSR       = 4'd5,
        TEST_HALT      = 4'd6
    } test_funct_t;

    typedef struct packed {
        logic [5:0]  imm;
        test_funct_t funct;
        logic [4:0]  rs_d;
        logic [4:0]  rs_0;
        logic [4:0]  rs_1;
        logic [6:0]  opcode;
    } test_insn_t;

    localparam logic [6:0] TEST_OPCODE_DEFAULT = 7'b0001011;
    localparam logic [3:0] TEST_FUNCT_MAX      = 4'd6;

    // funct is kept as a raw code so illegal values survive the FIFO and can be flagged
    typedef struct packed {
        logic [3:0] funct;
        logic [4:0] rs_d;
        logic [4:0] rs_0;
        logic [4:0] rs_1;
        logic [5:0] imm;
        logic [7:0] count;
    } test_cmd_t;

    function automatic logic funct_legal(input logic [3:0] funct);
        return funct <= TEST_FUNCT_MAX;
    endfunction

    function automatic test_insn_t encode_cmd(input test_cmd_t cmd, input logic [6:0] opcode);
        test_insn_t word;
        word.imm    = cmd.imm;
        word.funct  = test_funct_t'(cmd.funct);
        word.rs_d   = cmd.rs_d;
        word.rs_0   = cmd.rs_0;
        word.rs_1   = cmd.rs_1;
        word.opcode = opcode;
        return word;
    endfunction

endpackage

// File: rtl/test_insn_encoder_if.sv
// Command-in / instruction-out stream bundle of the test instruction encoder.
interface test_insn_encoder_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_funct;
    logic [4:0]  cmd_rs_d;
    logic [4:0]  cmd_rs_0;
    logic [4:0]  cmd_rs_1;
    logic [5:0]  cmd_imm;
    logic [7:0]  cmd_count;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic        illegal;
    logic        busy;
    logic [15:0] emitted;

    modport master (
        output cmd_valid, cmd_funct, cmd_rs_d, cmd_rs_0, cmd_rs_1, cmd_imm, cmd_count,
        output insn_ready,
        input  cmd_ready, insn_valid, insn, illegal, busy, emitted
    );

    modport slave (
        input  cmd_valid, cmd_funct, cmd_rs_d, cmd_rs_0, cmd_rs_1, cmd_imm, cmd_count,
        input  insn_ready,
        output cmd_ready, insn_valid, insn, illegal, busy, emitted
    );

endinterface

// File: rtl/test_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags. The head entry is visible
// combinationally so the emitter can pop it the cycle after it was written.
module test_cmd_fifo
    import test_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      srst,
    input  logic      push,
    input  test_cmd_t push_data,
    input  logic      pop,
    output test_cmd_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    test_cmd_t      mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/test_insn_encoder.sv
// Buffers test commands and serialises each into cmd_count+1 instruction words.
// Define TEST_INSN_ENC_AUTOINC_EN to step rs_d and imm on every repeat.
module test_insn_encoder
    import test_pkg::*;
#(
    parameter logic [6:0] OPCODE = TEST_OPCODE_DEFAULT,
    parameter int         DEPTH  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    test_insn_encoder_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]  state_reg, state_next;
    test_insn_t  insn_reg, insn_next;
    logic [7:0]  remaining_reg, remaining_next;
    logic        illegal_reg, illegal_next;
    logic [15:0] emitted_reg, emitted_next;

    test_cmd_t   cmd_in;
    test_cmd_t   head;
    logic        push, pop, take_head;
    logic        full, empty;

    function automatic test_insn_t next_repeat(input test_insn_t word);
        test_insn_t nxt;
        nxt = word;
`ifdef TEST_INSN_ENC_AUTOINC_EN
        nxt.rs_d = word.rs_d + 5'd1;
        nxt.imm  = word.imm + 6'd1;
`endif
        return nxt;
    endfunction

    assign cmd_in = '{funct: bus.cmd_funct, rs_d: bus.cmd_rs_d, rs_0: bus.cmd_rs_0,
                      rs_1: bus.cmd_rs_1, imm: bus.cmd_imm, count: bus.cmd_count};
    assign push   = bus.cmd_valid && !full;

    test_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .srst      (RST),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_next     = state_reg;
        insn_next      = insn_reg;
        remaining_next = remaining_reg;
        illegal_next   = 1'b0;
        emitted_next   = emitted_reg;
        take_head      = 1'b0;

        if (state_reg == IDLE) begin
            take_head = !empty;
        end else if (bus.insn_ready) begin
            emitted_next = emitted_reg + 16'd1;
            if (remaining_reg != 8'd0) begin
                remaining_next = remaining_reg - 8'd1;
                insn_next      = next_repeat(insn_reg);
            end else if (!empty) begin
                take_head = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end

        // Legal heads go straight into the output register so back-to-back commands have no bubble
        if (take_head) begin
            if (funct_legal(head.funct)) begin
                insn_next      = encode_cmd(head, OPCODE);
                remaining_next = head.count;
                state_next     = EMIT;
            end else begin
                illegal_next = 1'b1;
                state_next   = IDLE;
            end
        end
        pop = take_head;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            insn_reg      <= '0;
            remaining_reg <= '0;
            illegal_reg   <= 1'b0;
            emitted_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            insn_reg      <= insn_next;
            remaining_reg <= remaining_next;
            illegal_reg   <= illegal_next;
            emitted_reg   <= emitted_next;
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.insn_valid = (state_reg == EMIT);
    assign bus.insn       = insn_reg;
    assign bus.illegal    = illegal_reg;
    assign bus.busy       = !empty || (state_reg != IDLE);
    assign bus.emitted    = emitted_reg;

endmodule

// File: tb/tb_test_insn_encoder.sv
// Scoreboard bench for test_insn_encoder: a reference model queues expected words
// per accepted command and a monitor pops and compares on every output handshake.
module tb_test_insn_encoder;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    test_insn_encoder_if bus ();

    test_insn_encoder #(.OPCODE(7'b0001011), .DEPTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          model_emitted = 0;
    int          exp_illegal = 0;
    int          seen_illegal = 0;
    int          cyc = 0;
    int          last_hs_cyc = -1;
    int          prev_hs_cyc = -1;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_insn = '0;
    logic [31:0] exp_word;
    bit          rand_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Word value from the field layout: imm|funct|rs_d|rs_0|rs_1|opcode, repeat index k
    function automatic logic [31:0] ref_word(input int f, input int rd, input int r0,
                                             input int r1, input int imm, input int k);
        longint v;
        int rdk = rd;
        int immk = imm;
`ifdef TEST_INSN_ENC_AUTOINC_EN
        rdk  = (rd + k) % 32;
        immk = (imm + k) % 64;
`endif
        v = longint'(immk) * 64'd67108864 + longint'(f) * 64'd4194304 +
            longint'(rdk) * 64'd131072 + longint'(r0) * 64'd4096 +
            longint'(r1) * 64'd128 + 64'd11;
        return v[31:0];
    endfunction

    task automatic model_cmd(input int f, input int rd, input int r0, input int r1,
                             input int imm, input int cnt);
        if (f <= 6) begin
            for (int k = 0; k <= cnt; k++) begin
                exp_q.push_back(ref_word(f, rd, r0, r1, imm, k));
                model_emitted++;
            end
        end else begin
            exp_illegal++;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic push_cmd(input int f, input int rd, input int r0, input int r1,
                            input int imm, input int cnt);
        bit acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_funct = f[3:0];
        bus.cmd_rs_d  = rd[4:0];
        bus.cmd_rs_0  = r0[4:0];
        bus.cmd_rs_1  = r1[4:0];
        bus.cmd_imm   = imm[5:0];
        bus.cmd_count = cnt[7:0];
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge CLK);
            acc = bus.cmd_ready;
            @(posedge CLK);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (acc) begin
            model_cmd(f, rd, r0, r1, imm, cnt);
            $display("cmd  funct=%0d rs_d=%0d rs_0=%0d rs_1=%0d imm=%0d count=%0d", f, rd, r0, r1, imm, cnt);
        end else begin
            total++;
            bad++;
            $display("FAIL push_timeout: got cmd_ready=0 for 200 cycles required 1");
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int t = 0; t < 2000 && !idle; t++) begin
            @(negedge CLK);
            idle = !bus.busy && (exp_q.size() == 0);
        end
        if (!idle) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got busy=%0d pending=%0d required 0", bus.busy, exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: output handshakes, hold stability under backpressure, illegal pulses
    always @(negedge CLK) begin
        if (RST) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(bus.insn_valid), 32'd1);
                check("hold_insn", bus.insn, stall_insn);
            end
            if (bus.illegal) seen_illegal++;
            if (bus.insn_valid && bus.insn_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got 0x%08h required none", bus.insn);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("word", bus.insn, exp_word);
                end
                prev_hs_cyc = last_hs_cyc;
                last_hs_cyc = cyc;
            end
            stall_prev = bus.insn_valid && !bus.insn_ready;
            stall_insn = bus.insn;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hold_insn;
        logic [15:0] hold_em;

        bus.cmd_valid  = 1'b0;
        bus.cmd_funct  = '0;
        bus.cmd_rs_d   = '0;
        bus.cmd_rs_0   = '0;
        bus.cmd_rs_1   = '0;
        bus.cmd_imm    = '0;
        bus.cmd_count  = '0;
        bus.insn_ready = 1'b1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        @(negedge CLK);
        check("rst_insn_valid", 32'(bus.insn_valid), 32'd0);
        check("rst_insn", bus.insn, 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_emitted", 32'(bus.emitted), 32'd0);
        @(posedge CLK);
        #1;

        // Latency: accepted in cycle N, word valid in N+2 for one cycle
        push_cmd(0, 3, 1, 2, 0, 0);
        @(negedge CLK);
        check("lat_n1_valid", 32'(bus.insn_valid), 32'd0);
        @(negedge CLK);
        check("lat_n2_valid", 32'(bus.insn_valid), 32'd1);
        check("lat_n2_insn", bus.insn, 32'h0006110B);
        @(negedge CLK);
        check("lat_n3_valid", 32'(bus.insn_valid), 32'd0);
        check("emitted_one", 32'(bus.emitted), 32'd1);
        @(posedge CLK);
        #1;

        push_cmd(4, 0, 2, 7, 5, 2);
        wait_idle();
        push_cmd(1, 31, 4, 5, 63, 1);
        wait_idle();

        // Backpressure mid-burst, then fill the FIFO while stalled
        push_cmd(5, 1, 1, 1, 1, 5);
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        bus.insn_ready = 1'b0;
        @(negedge CLK);
        hold_insn = bus.insn;
        hold_em   = bus.emitted;
        @(negedge CLK);
        @(negedge CLK);
        check("stall_valid", 32'(bus.insn_valid), 32'd1);
        check("stall_insn", bus.insn, hold_insn);
        check("stall_emitted", 32'(bus.emitted), 32'(hold_em));
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) push_cmd(i, i + 1, i + 2, i + 3, i + 4, 0);
        @(negedge CLK);
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge CLK);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_funct = 4'd6;
        @(negedge CLK);
        check("full_refuse", 32'(bus.cmd_ready), 32'd0);
        @(posedge CLK);
        #1;
        bus.insn_ready = 1'b1;
        push_cmd(6, 9, 10, 11, 12, 0);
        wait_idle();

        // Illegal funct between two legal commands
        push_cmd(0, 1, 2, 3, 4, 0);
        push_cmd(9, 5, 5, 5, 5, 0);
        push_cmd(6, 7, 8, 9, 10, 0);
        wait_idle();
        check("illegal_gap", 32'(last_hs_cyc - prev_hs_cyc), 32'd2);
        check("illegal_seen", 32'(seen_illegal), 32'(exp_illegal));

        // Reset during the second repeat of a count=5 command
        push_cmd(2, 5, 6, 7, 8, 5);
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_q.delete();
        model_emitted = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_valid", 32'(bus.insn_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_emitted", 32'(bus.emitted), 32'd0);
        check("mid_rst_insn", bus.insn, 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge CLK);
        #1;
        push_cmd(3, 1, 2, 3, 4, 1);
        wait_idle();

        // Randomized commands with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int f;
                    f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 6));
                    push_cmd(f, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                             int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                             int'($urandom_range(0, 3)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.insn_ready = ($urandom_range(0, 3) != 0);
                    @(posedge CLK);
                    #1;
                end
                bus.insn_ready = 1'b1;
            end
        join
        wait_idle();

        check("final_illegal", 32'(seen_illegal), 32'(exp_illegal));
        check("final_emitted", 32'(bus.emitted), 32'(model_emitted % 65536));
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
